// File: rtl/ed25519_pkg.sv
// Shared constants and types for the ed25519 stream front-end.
package ed25519_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned PATN_W    = 256;
  localparam int unsigned IN_BEATS  = 3 * PATN_W / DATA_W;
  localparam int unsigned OUT_BEATS = 2 * PATN_W / DATA_W;
  localparam int unsigned IN_CNT_W  = $clog2(IN_BEATS);
  localparam int unsigned OUT_CNT_W = $clog2(OUT_BEATS);
  localparam int unsigned REQ_W     = 3 * PATN_W;
  localparam int unsigned RES_W     = 2 * PATN_W;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } io_state_t;

endpackage

// File: rtl/ed25519_io_ctrl.sv
// Stream front-end: collects 12 request beats, starts the core, and streams
// the 512-bit result back as 8 beats. All outputs come straight from flops.
module ed25519_io_ctrl
  import ed25519_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_start,
  output logic [PATN_W-1:0] o_scalar,
  output logic [PATN_W-1:0] o_px,
  output logic [PATN_W-1:0] o_py,
  input  logic              i_done,
  input  logic [PATN_W-1:0] i_rx,
  input  logic [PATN_W-1:0] i_ry
);

  io_state_t            state_q, state_d;
  logic [IN_CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [REQ_W-1:0]     req_q, req_d;
  logic [RES_W-1:0]     res_q, res_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 start_q, start_d;
  logic                 in_fire, out_fire;

  // Next-state, counters, request shift-in and result shift-out.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    req_d     = req_q;
    res_d     = res_q;
    in_fire   = i_in_valid && in_ready_q;
    out_fire  = out_valid_q && i_out_ready;

    case (state_q)
      RECV: begin
        if (in_fire) begin
          // First beat ends up at the top of scalar after all 12 shifts.
          req_d = {req_q[REQ_W-DATA_W-1:0], i_in_data};
          if (in_cnt_q == IN_CNT_W'(IN_BEATS - 1)) begin
            in_cnt_d = '0;
            state_d  = START;
          end else begin
            in_cnt_d = in_cnt_q + IN_CNT_W'(1);
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (i_done) begin
          res_d   = {i_rx, i_ry};
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_fire) begin
          res_d = {res_q[RES_W-DATA_W-1:0], DATA_W'(0)};
          if (out_cnt_q == OUT_CNT_W'(OUT_BEATS - 1)) begin
            out_cnt_d = '0;
            state_d   = RECV;
          end else begin
            out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
          end
        end
      end
      default: state_d = RECV;
    endcase

    in_ready_d  = (state_d == RECV);
    start_d     = (state_d == START);
    out_valid_d = (state_d == SEND);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= RECV;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      req_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      req_q       <= req_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      start_q     <= start_d;
    end
  end

  assign o_in_ready  = in_ready_q;
  assign o_out_valid = out_valid_q;
  assign o_start     = start_q;
  assign o_out_data  = res_q[RES_W-1 -: DATA_W];
  assign o_scalar    = req_q[REQ_W-1 -: PATN_W];
  assign o_px        = req_q[2*PATN_W-1 -: PATN_W];
  assign o_py        = req_q[PATN_W-1:0];

endmodule

// File: tb/tb_ed25519_io_ctrl.sv
// Self-checking bench for ed25519_io_ctrl: directed scenarios with random
// data and stalls, checked against a transaction-level reference.
module tb_ed25519_io_ctrl;
  import ed25519_pkg::*;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_in_valid = 1'b0;
  logic              o_in_ready;
  logic [DATA_W-1:0] i_in_data = '0;
  logic              o_out_valid;
  logic              i_out_ready = 1'b0;
  logic [DATA_W-1:0] o_out_data;
  logic              o_start;
  logic [PATN_W-1:0] o_scalar, o_px, o_py;
  logic              i_done = 1'b0;
  logic [PATN_W-1:0] i_rx = '0, i_ry = '0;

  ed25519_io_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_start(o_start), .o_scalar(o_scalar), .o_px(o_px), .o_py(o_py),
    .i_done(i_done), .i_rx(i_rx), .i_ry(i_ry)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] beats [IN_BEATS];
  logic [PATN_W-1:0] exp_s, exp_x, exp_y;
  logic [PATN_W-1:0] rx_v, ry_v;
  int lat;

  localparam logic [PATN_W-1:0] BASE_X =
    256'h216936D3CD6E53FEC0A4E231FDD6DC5C692CC7609525A7B2C9562D608F25D51A;
  localparam logic [PATN_W-1:0] BASE_Y =
    256'h6666666666666666666666666666666666666666666666666666666666666658;

  task automatic check(input string tag, input logic [PATN_W-1:0] obs,
                       input logic [PATN_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [PATN_W-1:0] rand256();
    logic [PATN_W-1:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[PATN_W-33:0], 32'($urandom())};
    return r;
  endfunction

  // Reference request: scalar, x, y split MSB-first into 12 beats.
  task automatic set_req(input logic [PATN_W-1:0] s, input logic [PATN_W-1:0] x,
                         input logic [PATN_W-1:0] y);
    logic [REQ_W-1:0] full;
    full = {s, x, y};
    for (int i = 0; i < IN_BEATS; i++) beats[i] = full[REQ_W-1-DATA_W*i -: DATA_W];
    exp_s = s; exp_x = x; exp_y = y;
  endtask

  task automatic set_rand_req;
    set_req(rand256(), rand256(), rand256());
  endtask

  // Drive n beats; a spurious i_done accompanies beat spur_idx.
  task automatic send_request(input int n, input bit stall, input int spur_idx,
                              output int first_lat);
    int  k = 0;
    int  cyc = 0;
    bit  acc;
    first_lat = -1;
    while (k < n && cyc < 400) begin
      i_in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      i_in_data  = beats[k];
      i_done     = (k == spur_idx);
      i_rx       = rand256();
      i_ry       = rand256();
      acc        = i_in_valid && o_in_ready;
      cyc++;
      tick;
      i_done = 1'b0;
      if (acc) begin
        if (k == 0) first_lat = cyc;
        k++;
        if (k < IN_BEATS) begin
          check1("no_start_while_recv", o_start, 1'b0);
          check1("no_outvalid_while_recv", o_out_valid, 1'b0);
        end
      end
    end
    i_in_valid = 1'b0;
    check("in_beats_accepted", 256'(k), 256'(n));
    if (n == IN_BEATS) begin
      check1("start_after_beat11", o_start, 1'b1);
      check1("in_ready_low_in_start", o_in_ready, 1'b0);
      check("scalar", o_scalar, exp_s);
      check("px", o_px, exp_x);
      check("py", o_py, exp_y);
      tick;
      check1("start_one_cycle", o_start, 1'b0);
    end
  endtask

  // Core model: wait dly cycles (input stream pushing meanwhile), then done.
  task automatic core(input logic [PATN_W-1:0] rx, input logic [PATN_W-1:0] ry,
                      input int dly);
    for (int i = 0; i < dly; i++) begin
      i_in_valid = 1'b1;
      i_in_data  = DATA_W'({$urandom(), $urandom()});
      check1("wait_in_ready_low", o_in_ready, 1'b0);
      check1("wait_no_outvalid", o_out_valid, 1'b0);
      tick;
    end
    i_in_valid = 1'b0;
    check("wait_py_hold", o_py, exp_y);
    i_done = 1'b1;
    i_rx = rx;
    i_ry = ry;
    tick;
    i_done = 1'b0;
    i_rx = rand256();
    i_ry = rand256();
    check1("outvalid_after_done", o_out_valid, 1'b1);
    check("first_out_beat", 256'(o_out_data), 256'(rx[PATN_W-1 -: DATA_W]));
  endtask

  // Collect stop_at beats; hold_n cycles of initial backpressure.
  task automatic recv_result(input logic [PATN_W-1:0] rx, input logic [PATN_W-1:0] ry,
                             input bit stall, input int hold_n, input int stop_at);
    logic [RES_W-1:0]  res;
    logic [DATA_W-1:0] prev;
    int  k = 0;
    int  cyc = 0;
    bit  acc, held;
    res = {rx, ry};
    for (int i = 0; i < hold_n; i++) begin
      i_out_ready = 1'b0;
      tick;
      check1("hold_valid", o_out_valid, 1'b1);
      check("hold_data", 256'(o_out_data), 256'(rx[PATN_W-1 -: DATA_W]));
    end
    while (k < stop_at && cyc < 400) begin
      i_out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      acc  = o_out_valid && i_out_ready;
      held = o_out_valid && !i_out_ready;
      prev = o_out_data;
      if (acc) begin
        check("out_beat", 256'(o_out_data), 256'(res[RES_W-1-DATA_W*k -: DATA_W]));
        k++;
      end
      cyc++;
      tick;
      if (held) check("stall_data_stable", 256'(o_out_data), 256'(prev));
    end
    i_out_ready = 1'b0;
    check("out_beats_seen", 256'(k), 256'(stop_at));
    if (stop_at == OUT_BEATS) begin
      if (!stall) check("out_consecutive", 256'(cyc), 256'(OUT_BEATS));
      check1("in_ready_after_send", o_in_ready, 1'b1);
      check1("outvalid_drops", o_out_valid, 1'b0);
    end
  endtask

  task automatic do_reset;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    i_done      = 1'b0;
    i_rst       = 1'b1;
    tick;
    check1("rst_in_ready", o_in_ready, 1'b0);
    check1("rst_out_valid", o_out_valid, 1'b0);
    check1("rst_start", o_start, 1'b0);
    check("rst_out_data", 256'(o_out_data), '0);
    check("rst_scalar", o_scalar, '0);
    check("rst_px", o_px, '0);
    check("rst_py", o_py, '0);
    i_rst = 1'b0;
    tick;
    check1("post_rst_in_ready", o_in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check1("post_rst_no_start", o_start, 1'b0);
      check1("post_rst_no_out", o_out_valid, 1'b0);
      tick;
    end
  endtask

  task automatic full_txn(input bit stall, input int hold_n);
    logic [PATN_W-1:0] rx, ry;
    int l;
    rx = rand256();
    ry = rand256();
    send_request(IN_BEATS, stall, -1, l);
    core(rx, ry, 1 + int'($urandom_range(0, 4)));
    recv_result(rx, ry, stall, hold_n, OUT_BEATS);
  endtask

  initial begin
    do_reset;

    // Continuous handshake with the base point and fixed core result.
    set_req(256'd1, BASE_X, BASE_Y);
    rx_v = {4{64'h1111111111111111}};
    ry_v = {4{64'h2222222222222222}};
    send_request(IN_BEATS, 1'b0, -1, lat);
    check("first_beat_latency", 256'(lat), 256'(1));
    core(rx_v, ry_v, 3);
    recv_result(rx_v, ry_v, 1'b0, 0, OUT_BEATS);

    // Random stalls with descending-index beats.
    for (int i = 0; i < IN_BEATS; i++) beats[i] = DATA_W'(IN_BEATS - 1 - i);
    exp_s = {64'd11, 64'd10, 64'd9, 64'd8};
    exp_x = {64'd7, 64'd6, 64'd5, 64'd4};
    exp_y = {64'd3, 64'd2, 64'd1, 64'd0};
    send_request(IN_BEATS, 1'b1, -1, lat);
    check("scalar_top_0b", 256'(o_scalar[PATN_W-1 -: DATA_W]), 256'(64'h0B));
    check("py_low_00", 256'(o_py[DATA_W-1:0]), '0);
    core(rx_v, ry_v, 2);
    recv_result(rx_v, ry_v, 1'b1, 0, OUT_BEATS);

    // Backpressure hold at SEND entry.
    set_rand_req;
    full_txn(1'b0, 5);

    // Spurious done during beat 6, input valid held during WAIT.
    set_rand_req;
    rx_v = rand256();
    ry_v = rand256();
    send_request(IN_BEATS, 1'b0, 6, lat);
    core(rx_v, ry_v, 6);
    recv_result(rx_v, ry_v, 1'b0, 0, OUT_BEATS);

    // Reset after input beat 7, then a fresh request.
    set_rand_req;
    send_request(8, 1'b0, -1, lat);
    do_reset;
    set_rand_req;
    full_txn(1'b1, 0);

    // Reset after output beat 3, then a fresh request.
    set_rand_req;
    rx_v = rand256();
    ry_v = rand256();
    send_request(IN_BEATS, 1'b0, -1, lat);
    core(rx_v, ry_v, 2);
    recv_result(rx_v, ry_v, 1'b0, 0, 4);
    do_reset;
    set_rand_req;
    full_txn(1'b0, 0);

    // Back-to-back: second request starts the cycle after output beat 7.
    set_rand_req;
    full_txn(1'b0, 0);
    set_rand_req;
    rx_v = rand256();
    ry_v = rand256();
    send_request(IN_BEATS, 1'b0, -1, lat);
    check("b2b_first_beat_latency", 256'(lat), 256'(1));
    core(rx_v, ry_v, 1);
    recv_result(rx_v, ry_v, 1'b0, 0, OUT_BEATS);

    // Random traffic with stalls on both sides.
    for (int t = 0; t < 4; t++) begin
      set_rand_req;
      full_txn(1'b1, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ed25519_io_ctrl.md
# ed25519_io_ctrl

Stream front-end of the `ed25519` top. It receives the 768-bit request (scalar, point x, point y) as twelve 64-bit valid/ready beats and presents it to the scalar-multiplication core with a one-cycle start pulse. It captures the 512-bit result when the core signals done, then streams it back as eight 64-bit valid/ready beats. It is the receiving end of the bench's input stream and the transmitting end of its output stream.

## Interface
- `DATA_W`, 64, stream beat width
- `PATN_W`, 256, coordinate/scalar width
- `i_clk` in 1 — clock
- `i_rst` in 1 — synchronous, active-high reset
- `i_in_valid` in 1 — input beat valid
- `o_in_ready` out 1 — block can accept an input beat
- `i_in_data` in DATA_W — input beat
- `o_out_valid` out 1 — output beat valid
- `i_out_ready` in 1 — sink accepts output beat
- `o_out_data` out DATA_W — output beat
- `o_start` out 1 — one-cycle pulse; core operands valid
- `o_scalar`, `o_px`, `o_py` out PATN_W each — registered operands, stable from `o_start` until the next request begins loading
- `i_done` in 1 — one-cycle pulse from core; result valid
- `i_rx`, `i_ry` in PATN_W each — core result, sampled only on `i_done`

## Operation
- Transfer rule: a beat moves on a rising edge where valid && ready. No other condition transfers a beat.
- FSM states: RECV, START, WAIT, SEND.
  - RECV: `o_in_ready`=1; each accepted beat increments `in_cnt` (0..11). Beats load MSB-first: beats 0–3 fill `o_scalar[255:0]` from top to bottom, beats 4–7 fill `o_px`, beats 8–11 fill `o_py`. Accepting beat 11 moves to START.
  - START: `o_start`=1 for exactly this cycle, then WAIT.
  - WAIT: on `i_done`=1, latch `{i_rx,i_ry}` into a 512-bit output buffer and go to SEND.
  - SEND: `o_out_valid`=1 with `o_out_data` = top 64 bits of the buffer. On each accepted beat the buffer shifts left by 64 and `out_cnt` increments (0..7). Order is rx[255:192] first, ry[63:0] last. Accepting beat 7 moves to RECV with counters cleared.
- `o_in_ready`=0 in START, WAIT and SEND. Input beats offered in those states are not consumed.
- `i_done` outside WAIT is ignored.
- While `o_out_valid`=1 and `i_out_ready`=0, `o_out_data` is held stable.
- Reset values: state=RECV, `in_cnt`=`out_cnt`=0, `o_in_ready`=0 during reset and 1 from the first cycle after, `o_out_valid`=0, `o_out_data`=0, `o_start`=0, operand registers=0, output buffer=0.
- Reset mid-operation, in any state: the partial request and any pending result are discarded and the block returns to RECV. No `o_start` pulse and no output beat follows reset.

## Timing
- Input throughput: 1 beat/cycle; 12 beats take at minimum 12 cycles.
- `o_start` rises the cycle after beat 11 is accepted.
- `o_out_valid` rises the cycle after `i_done`.
- Output throughput: 1 beat/cycle while `i_out_ready`=1.
- `o_in_ready` rises the cycle after output beat 7 is accepted. A new request is fully back-to-back; there are no idle cycles beyond this one.
- All outputs are registered, with no combinational path from any input to any output.
- Random stalls on either side (valid or ready toggling every cycle) change only the latency, never the data or its order.

## Structure
- The shared package `ed25519_pkg` holds:
  - `DATA_W`, `PATN_W`
  - `IN_BEATS`=3*PATN_W/DATA_W (12) and `OUT_BEATS`=2*PATN_W/DATA_W (8)
  - the `io_state_t` enum {RECV, START, WAIT, SEND}
- No sub-module. The block is a single FSM with two counters, the operand registers and the output shift buffer.

## Test plan
- Continuous handshake: scalar=…0001, px/py = the base point → `o_start` in the cycle after beat 11. Core model returns rx=0x11…11, ry=0x22…22 → eight beats 0x1111111111111111 ×4 then 0x2222222222222222 ×4, on consecutive cycles.
- Random stalls: `i_in_valid` and `i_out_ready` driven by $random%2, with beats 64'h0…0B down to 64'h0…00 (descending index) → `o_scalar[255:192]`=0x0B and `o_py[63:0]`=0x00. Output sequence identical to the continuous case.
- Backpressure hold: hold `i_out_ready`=0 for 5 cycles at SEND entry → `o_out_valid`=1 with `o_out_data`=rx[255:192] constant for all 5 cycles.
- Spurious done: pulse `i_done` during RECV beat 6 → ignored, no `o_out_valid`. `i_in_valid` held during WAIT → `o_in_ready`=0 and `in_cnt` unchanged.
- Reset after beat 7 accepted and after output beat 3 accepted → all outputs at reset values. A fresh 12-beat request then produces the correct full result.
- Back-to-back requests: the second request's first beat is accepted in the cycle after the first request's output beat 7. Both results are correct.
